mem_dp_be: RTL and testbench

- Parametrised simple-dual-port SRAM model: one write port and one read port, both on one clock.
- Adds per-byte write enables, selectable read-during-write behaviour, 1- or 2-cycle read latency with a valid flag, and an optional hardware clear-on-reset sequencer.
- Used as the line/coefficient buffer in Filter2D and later DSP blocks that need a concurrent write and read.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_dp_be_if.sv | 28 ++
 rtl/mem_clear_seq.sv | 72 +++++++
 rtl/mem_dp_be.sv | 129 ++++++++++++
 tb/tb_mem_dp_be.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-enabled dual-port memory family.
package mem_pkg;

   // Read-during-write selection for same-address collisions
   localparam int unsigned RDW_OLD = 0;
   localparam int unsigned RDW_NEW = 1;

   // Widest word the merge helper handles; callers size-cast in and out
   localparam int unsigned MAX_WD = 1024;
   localparam int unsigned MAX_NB = MAX_WD / 8;

   // Clear sequencer states
   typedef enum logic {
      StIdle,
      StClear
   } clr_state_e;

   // Byte-lane merge: lanes with be=1 come from new_w, the rest from old_w
   function automatic logic [MAX_WD-1:0] byte_merge(input logic [MAX_WD-1:0] old_w,
                                                    input logic [MAX_WD-1:0] new_w,
                                                    input logic [MAX_NB-1:0] be);
      logic [MAX_WD-1:0] res;
      res = old_w;
      for (int i = 0; i < int'(MAX_NB); i++) begin
         if (be[i]) begin
            res[8*i +: 8] = new_w[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_dp_be_if.sv
// Write/read port bundle for mem_dp_be; master drives requests, slave answers.
interface mem_dp_be_if #(
   parameter int unsigned WD = 128,
   parameter int unsigned WA = 6
);
   localparam int unsigned NB = WD / 8;

   logic          busy;
   logic          we;
   logic [WA-1:0] waddr;
   logic [WD-1:0] wdata;
   logic [NB-1:0] wbe;
   logic          re;
   logic [WA-1:0] raddr;
   logic [WD-1:0] rdata;
   logic          rvalid;

   modport master (
      output we, waddr, wdata, wbe, re, raddr,
      input  busy, rdata, rvalid
   );

   modport slave (
      input  we, waddr, wdata, wbe, re, raddr,
      output busy, rdata, rvalid
   );

endinterface

// File: rtl/mem_clear_seq.sv
// Post-reset clear sequencer: zeroes one word per cycle, then hands the write
// port to the user. Also filters out-of-range user writes.
module mem_clear_seq
   import mem_pkg::*;
#(
   parameter int unsigned WD           = 128,
   parameter int unsigned DEPTH        = 64,
   parameter int unsigned WA           = $clog2(DEPTH),
   parameter int unsigned CLEAR_ON_RST = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we_i,
   input  logic [WA-1:0]   waddr_i,
   input  logic [WD-1:0]   wdata_i,
   input  logic [WD/8-1:0] wbe_i,
   output logic            busy_o,
   output logic            mem_we_o,
   output logic [WA-1:0]   mem_waddr_o,
   output logic [WD-1:0]   mem_wdata_o,
   output logic [WD/8-1:0] mem_wbe_o
);

   clr_state_e    state_q, state_d;
   logic [WA-1:0] cnt_q, cnt_d;

   // State and counter registers; reset restarts the clear from word 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= (CLEAR_ON_RST != 0) ? StClear : StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: walk cnt through 0..DEPTH-1, then go idle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StClear: begin
            if (32'(cnt_q) == DEPTH - 1) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + WA'(1);
            end
         end
         StIdle:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs: busy flag and the write-port mux (clear word vs user write)
   always_comb begin
      busy_o = (state_q == StClear);
      if (busy_o) begin
         mem_we_o    = 1'b1;
         mem_waddr_o = cnt_q;
         mem_wdata_o = '0;
         mem_wbe_o   = '1;
      end else begin
         mem_we_o    = we_i && (32'(waddr_i) < DEPTH);
         mem_waddr_o = waddr_i;
         mem_wdata_o = wdata_i;
         mem_wbe_o   = wbe_i;
      end
   end

endmodule

// File: rtl/mem_dp_be.sv
// Simple-dual-port SRAM model with byte enables, selectable read-during-write
// result, 1/2-cycle read latency and optional clear after reset.
module mem_dp_be
   import mem_pkg::*;
#(
   parameter int unsigned WD           = 128,
   parameter int unsigned DEPTH        = 64,
   parameter int unsigned WA           = $clog2(DEPTH),
   parameter int unsigned RD_LAT       = 1,
   parameter int unsigned RDW_MODE     = RDW_OLD,
   parameter int unsigned CLEAR_ON_RST = 1
) (
   input logic        clk,
   input logic        rst,
   mem_dp_be_if.slave bus
);

   // Lane count is derived from WD, never set independently
   localparam int unsigned NB = WD / 8;

   logic          busy;
   logic          mem_we;
   logic [WA-1:0] mem_waddr;
   logic [WD-1:0] mem_wdata;
   logic [NB-1:0] mem_wbe;

   mem_clear_seq #(
      .WD           (WD),
      .DEPTH        (DEPTH),
      .WA           (WA),
      .CLEAR_ON_RST (CLEAR_ON_RST)
   ) u_clear_seq (
      .clk         (clk),
      .rst         (rst),
      .we_i        (bus.we),
      .waddr_i     (bus.waddr),
      .wdata_i     (bus.wdata),
      .wbe_i       (bus.wbe),
      .busy_o      (busy),
      .mem_we_o    (mem_we),
      .mem_waddr_o (mem_waddr),
      .mem_wdata_o (mem_wdata),
      .mem_wbe_o   (mem_wbe)
   );

   assign bus.busy = busy;

   // Storage array (contents deliberately not reset)
   logic [WD-1:0] mem_q [DEPTH];
   logic [WD-1:0] wr_word_d;

   // Write word: old contents with enabled lanes replaced
   always_comb begin
      wr_word_d = WD'(byte_merge(MAX_WD'(mem_q[mem_waddr]), MAX_WD'(mem_wdata),
                                 MAX_NB'(mem_wbe)));
   end

   // Array write port
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= wr_word_d;
      end
   end

   logic          rd_accept;
   logic          rd_in_range;
   logic          rdw_hit;
   logic [WD-1:0] rd_word;

   // Read word: out-of-range gives zero; optional bypass of a same-address write
   always_comb begin
      rd_accept   = bus.re && !busy;
      rd_in_range = 32'(bus.raddr) < DEPTH;
      rd_word     = rd_in_range ? mem_q[bus.raddr] : '0;
      rdw_hit     = (RDW_MODE == RDW_NEW) && mem_we && (mem_waddr == bus.raddr) && rd_in_range;
      if (rdw_hit) begin
         rd_word = WD'(byte_merge(MAX_WD'(rd_word), MAX_WD'(mem_wdata), MAX_NB'(mem_wbe)));
      end
   end

   logic [WD-1:0] rdata1_q, rdata1_d;
   logic          rvalid1_q, rvalid1_d;

   // First read stage next-state: capture on accept, otherwise hold data
   always_comb begin
      rvalid1_d = rd_accept;
      rdata1_d  = rd_accept ? rd_word : rdata1_q;
   end

   // First read stage registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata1_q  <= '0;
         rvalid1_q <= 1'b0;
      end else begin
         rdata1_q  <= rdata1_d;
         rvalid1_q <= rvalid1_d;
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic [WD-1:0] rdata2_q, rdata2_d;
      logic          rvalid2_q, rvalid2_d;

      // Output stage next-state: forward valid stage-1 data, otherwise hold
      always_comb begin
         rvalid2_d = rvalid1_q;
         rdata2_d  = rvalid1_q ? rdata1_q : rdata2_q;
      end

      // Output stage registers
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rdata2_q  <= '0;
            rvalid2_q <= 1'b0;
         end else begin
            rdata2_q  <= rdata2_d;
            rvalid2_q <= rvalid2_d;
         end
      end

      assign bus.rdata  = rdata2_q;
      assign bus.rvalid = rvalid2_q;
   end else begin : g_lat1
      assign bus.rdata  = rdata1_q;
      assign bus.rvalid = rvalid1_q;
   end

endmodule

// File: tb/tb_mem_dp_be.sv
// Bench for mem_dp_be: two instances driven in lockstep.
//   A: DEPTH=16, RD_LAT=1, old-data read-during-write
//   B: DEPTH=12, RD_LAT=2, new-data read-during-write
// Stimulus pushes expected reads (data + arrival cycle) and direct checks into
// queues; one monitor process does every comparison.
module tb_mem_dp_be;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_dp_be_if #(.WD(32), .WA(4)) bus_a ();
   mem_dp_be_if #(.WD(32), .WA(4)) bus_b ();

   mem_dp_be #(
      .WD(32), .DEPTH(16), .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RST(1)
   ) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.slave)
   );

   mem_dp_be #(
      .WD(32), .DEPTH(12), .RD_LAT(2), .RDW_MODE(1), .CLEAR_ON_RST(1)
   ) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] cyc;
   } exp_t;

   typedef struct packed {
      logic [95:0] name;
      logic [31:0] act;
      logic [31:0] req;
   } chk_t;

   exp_t        qa[$];
   exp_t        qb[$];
   chk_t        qc[$];
   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic        done = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input logic [95:0] name, input logic [31:0] act, input logic [31:0] req);
      chk_t c;
      c.name = name;
      c.act  = act;
      c.req  = req;
      qc.push_back(c);
   endtask

   // One cycle of stimulus on both instances; called right after a negedge
   task automatic op(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                     input logic [3:0] be, input logic re, input logic [3:0] ra,
                     input logic pa, input logic [31:0] ea,
                     input logic pb, input logic [31:0] eb);
      exp_t e;
      bus_a.we = we;  bus_a.waddr = wa;  bus_a.wdata = wd;  bus_a.wbe = be;
      bus_a.re = re;  bus_a.raddr = ra;
      bus_b.we = we;  bus_b.waddr = wa;  bus_b.wdata = wd;  bus_b.wbe = be;
      bus_b.re = re;  bus_b.raddr = ra;
      if (re && pa) begin
         e.data = ea;
         e.cyc  = cyc + 1;
         qa.push_back(e);
      end
      if (re && pb) begin
         e.data = eb;
         e.cyc  = cyc + 2;
         qb.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic nop();
      op(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      op(1'b1, a, d, be, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] ea, input logic [31:0] eb);
      op(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, a, 1'b1, ea, 1'b1, eb);
   endtask

   // Release reset and hold re high through the clear; only reads issued once
   // the clear is over (A: from cycle 16, B: from cycle 12) may return data.
   task automatic clear_run();
      int na;
      int nb;
      na  = 0;
      nb  = 0;
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (bus_a.busy) na++;
         if (bus_b.busy) nb++;
         op(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(k), k >= 16, 32'd0, k >= 12, 32'd0);
      end
      chk("a_busy_len", 32'(na), 32'd16);
      chk("b_busy_len", 32'(nb), 32'd12);
   endtask

   task automatic chk_rst_outputs();
      chk("a_rst_rdata", bus_a.rdata, 32'd0);
      chk("a_rst_rvalid", 32'(bus_a.rvalid), 32'd0);
      chk("a_rst_busy", 32'(bus_a.busy), 32'd1);
      chk("b_rst_rdata", bus_b.rdata, 32'd0);
      chk("b_rst_rvalid", 32'(bus_b.rvalid), 32'd0);
      chk("b_rst_busy", 32'(bus_b.busy), 32'd1);
   endtask

   // Stimulus
   initial begin
      logic [31:0] v;
      bus_a.we = 1'b0; bus_a.waddr = '0; bus_a.wdata = '0; bus_a.wbe = '0;
      bus_a.re = 1'b0; bus_a.raddr = '0;
      bus_b.we = 1'b0; bus_b.waddr = '0; bus_b.wdata = '0; bus_b.wbe = '0;
      bus_b.re = 1'b0; bus_b.raddr = '0;
      rst = 1'b1;
      #1;
      chk_rst_outputs();
      @(negedge clk);
      @(negedge clk);
      clear_run();

      // Whole array reads zero after clear (B addresses 12..15 are out of range)
      for (int i = 0; i < 16; i++) rd(4'(i), 32'd0, 32'd0);

      // Byte-enable merge
      wr(4'd3, 32'hAABBCCDD, 4'b1111);
      wr(4'd3, 32'h11223344, 4'b0101);
      rd(4'd3, 32'hAA22CC44, 32'hAA22CC44);

      // Same-address read-during-write, full and partial byte enables
      wr(4'd5, 32'hDEADBEEF, 4'hF);
      op(1'b1, 4'd5, 32'h12345678, 4'hF, 1'b1, 4'd5, 1'b1, 32'hDEADBEEF, 1'b1, 32'h12345678);
      rd(4'd5, 32'h12345678, 32'h12345678);
      op(1'b1, 4'd5, 32'h9999AAAA, 4'b0011, 1'b1, 4'd5, 1'b1, 32'h12345678, 1'b1, 32'h1234AAAA);
      rd(4'd5, 32'h1234AAAA, 32'h1234AAAA);

      // Different addresses in the same cycle do not interact
      op(1'b1, 4'd6, 32'h0BADF00D, 4'hF, 1'b1, 4'd5, 1'b1, 32'h1234AAAA, 1'b1, 32'h1234AAAA);
      rd(4'd6, 32'h0BADF00D, 32'h0BADF00D);

      // Back-to-back reads of 0..7, latency checked per item
      for (int i = 0; i < 8; i++) wr(4'(i), 32'h10000000 + 32'(i) * 32'h01010101, 4'hF);
      for (int i = 0; i < 8; i++) begin
         v = 32'h10000000 + 32'(i) * 32'h01010101;
         rd(4'(i), v, v);
      end
      nop();

      // wbe=0 is a no-op
      wr(4'd3, 32'h00000000, 4'b0000);
      rd(4'd3, 32'h13030303, 32'h13030303);

      // Out-of-range handling (13 is in range for A only)
      wr(4'd11, 32'hCAFEF00D, 4'hF);
      wr(4'd13, 32'hFFFFFFFF, 4'hF);
      rd(4'd13, 32'hFFFFFFFF, 32'h00000000);
      rd(4'd12, 32'h00000000, 32'h00000000);
      rd(4'd11, 32'hCAFEF00D, 32'hCAFEF00D);
      repeat (4) nop();
      chk("a_hold_rdata", bus_a.rdata, 32'hCAFEF00D);
      chk("b_hold_rdata", bus_b.rdata, 32'hCAFEF00D);

      // Async reset mid-cycle, then again at cnt=7 of the clear
      #2 rst = 1'b1;
      #1;
      chk_rst_outputs();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 7; k++) op(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(k), 1'b0, 32'd0, 1'b0, 32'd0);
      rst = 1'b1;
      #1;
      chk_rst_outputs();
      @(negedge clk);
      clear_run();
      rd(4'd3, 32'd0, 32'd0);
      rd(4'd11, 32'd0, 32'd0);
      repeat (6) nop();
      done = 1'b1;
   end

   // Monitor: all comparisons happen here
   initial forever begin
      chk_t c;
      exp_t e;
      @(negedge clk);
      while (qc.size() > 0) begin
         c = qc.pop_front();
         n_cmp++;
         if (c.act !== c.req) begin
            n_err++;
            $display("FAIL %0s: got %h, want %h", c.name, c.act, c.req);
         end
      end
      if (bus_a.rvalid) begin
         n_cmp++;
         if (qa.size() == 0) begin
            n_err++;
            $display("FAIL a_read: got rvalid with %h at cyc %0d, want no rvalid", bus_a.rdata, cyc);
         end else begin
            e = qa.pop_front();
            if (bus_a.rdata !== e.data || cyc != e.cyc) begin
               n_err++;
               $display("FAIL a_read: got %h at cyc %0d, want %h at cyc %0d",
                        bus_a.rdata, cyc, e.data, e.cyc);
            end
         end
      end
      if (bus_b.rvalid) begin
         n_cmp++;
         if (qb.size() == 0) begin
            n_err++;
            $display("FAIL b_read: got rvalid with %h at cyc %0d, want no rvalid", bus_b.rdata, cyc);
         end else begin
            e = qb.pop_front();
            if (bus_b.rdata !== e.data || cyc != e.cyc) begin
               n_err++;
               $display("FAIL b_read: got %h at cyc %0d, want %h at cyc %0d",
                        bus_b.rdata, cyc, e.data, e.cyc);
            end
         end
      end
      if (done) begin
         while (qa.size() > 0) begin
            e = qa.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL a_missing: got no rvalid, want %h at cyc %0d", e.data, e.cyc);
         end
         while (qb.size() > 0) begin
            e = qb.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL b_missing: got no rvalid, want %h at cyc %0d", e.data, e.cyc);
         end
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
         $finish;
      end
   end

endmodule
